// File: rtl/lpif_txrx_x8_q2_slave_txfifo.sv
// Purpose: shallow elastic buffer between the x8/Q2 slave LPIF packer and the link TX path, with optional idle-word drop.
// Latency: 1 cycle push-to-out_vld; show-ahead head, 1 word/cycle sustained when o_out_vld && i_out_rdy.
// Backpressure: o_in_rdy = !full (registered); words offered while full are lost and raise sticky o_overflow.
module lpif_txrx_x8_q2_slave_txfifo #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 537,
    parameter bit DROP_IDLE = 1'b1
) (
    input  logic                     i_clk_wr,
    input  logic                     i_rst_wr_n,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_vld,
    output logic                     o_in_rdy,
    output logic [WIDTH-1:0]         o_out_data,
    output logic                     o_out_vld,
    input  logic                     i_out_rdy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_is_idle;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;

    // Handshake decode; full/empty come only from registered count so
    // neither ready nor valid has a path from the opposite-side inputs.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        // Idle words complete the handshake but never touch state.
        w_is_idle = DROP_IDLE && !i_in_data[WIDTH-1];
        // No full bypass: a pop in the same cycle does not free a slot.
        w_push    = i_in_vld && !w_full && !w_is_idle;
        // No fall-through: an empty buffer cannot pop the word being pushed.
        w_pop     = !w_empty && i_out_rdy;
        // A word that would have been dropped anyway is not an overflow.
        w_ovf_set = i_in_vld && w_full && !w_is_idle;
    end

    // Storage array: reset clears every entry so the head reads 0 after reset.
    always_ff @(posedge i_clk_wr) begin
        if (!i_rst_wr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracked explicitly.
    always_ff @(posedge i_clk_wr) begin
        if (!i_rst_wr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow flag; a new overflow wins over a clear in the same cycle.
    always_ff @(posedge i_clk_wr) begin
        if (!i_rst_wr_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        o_in_rdy   = !w_full;
        o_out_vld  = !w_empty;
        o_out_data = r_mem[r_rd_ptr];
        o_count    = r_count;
        o_overflow = r_overflow;
    end

endmodule
